br_unit: RTL and testbench
==========================

// Module: br_unit
// PURPOSE
//  Registered branch/JALR resolution stage with an integrated branch history table (BHT).
//  Sits at the end of EX and resolves conditional branches and JALR against the prediction
//  that fetch supplied. Produces a one-cycle-late redirect and trains a table of 2-bit
//  saturating counters. Fetch reads the table combinationally. Also keeps branch and
//  mispredict performance counters.
// PARAMETERS
//  XLEN       64  datapath/address width (32 or 64)
//  BHT_DEPTH  64  number of 2-bit counters; must be a power of two, >= 2
//  CNT_W      32  width of each performance counter
// PORTS
//  clk           in   1     clock, rising edge
//  rst_n         in   1     asynchronous active-low reset
//  ex_valid      in   1     instruction in EX is valid
//  ex_pc         in   XLEN  PC of the EX instruction
//  ex_ir         in   32    instruction word
//  ex_r1         in   XLEN  rs1 operand (already forwarded)
//  ex_r2         in   XLEN  rs2 operand (already forwarded)
//  ex_pr_taken   in   1     fetch predicted this instruction taken
//  stall         in   1     hold the stage: no capture, no BHT/counter update
//  flush         in   1     kill the EX instruction and clear outputs at the next edge
//  lk_pc         in   XLEN  fetch lookup PC
//  lk_taken      out  1     lookup prediction = bht[idx(lk_pc)][1]
//  res_valid     out  1     registered: a branch or JALR was resolved last cycle
//  redirect      out  1     registered: fetch must restart at redirect_addr
//  redirect_addr out  XLEN  registered restart address
//  misalign      out  1     registered: taken target has bit1 set (target-misaligned fault)
//  br_cnt        out  CNT_W resolved conditional branches
//  miss_cnt      out  CNT_W mispredicted conditional branches
// BEHAVIOUR
//  - Reset (async, rst_n=0): res_valid, redirect and misalign go to 0. redirect_addr goes
//    to 0. br_cnt and miss_cnt go to 0. Every BHT entry goes to 2'b01 (weakly not-taken).
//  - idx(pc) = pc[$clog2(BHT_DEPTH)+1:2]. Lookup is combinational. On a same-cycle update
//    of the same index, lookup returns the pre-update value.
//  - Capture condition: cap = ex_valid & ~stall & ~flush.
//  - Decode, using ex_ir[6:0]:
//    - BR: opcode 1100011. funct3 selects the compare: 000 eq, 001 ne, 100 lt signed,
//      101 ge signed, 110 ltu, 111 geu. funct3 010/011 are illegal: treated as not taken,
//      no BHT update, not counted.
//    - JALR: opcode 1100111. target = (r1 + sext(ir[31:20])) & ~1.
//    - Any other opcode: nothing is registered; res_valid=0 at the next edge.
//  - Branch target: pc + sext({ir[31],ir[7],ir[30:25],ir[11:8],1'b0}). All arithmetic is
//    modulo 2^XLEN; wrap-around is legal.
//  - Latency: exactly 1 cycle from cap to res_valid/redirect. Outputs hold a single cycle
//    unless stall=1, in which case all registered outputs hold their value.
//  - BR resolved with taken bit t:
//    - redirect = (t != ex_pr_taken).
//    - redirect_addr = t ? target : pc+4.
//    - misalign = t & target[1].
//    - BHT: saturating increment if t, else saturating decrement. 11 stays 11; 00 stays 00.
//    - br_cnt += 1; miss_cnt += redirect. Both wrap modulo 2^CNT_W.
//  - JALR: redirect=1 always. redirect_addr = target. misalign = target[1]. No BHT update,
//    not counted.
//  - flush=1 has priority over stall. At the next edge: res_valid=0, redirect=0,
//    misalign=0, redirect_addr keeps its value. No BHT/counter update for the killed
//    instruction.
//  - Cycles with ex_valid=0 and stall=0: at the next edge res_valid=0, redirect=0,
//    misalign=0.
//  - Reset asserted mid-operation clears everything immediately; a pending redirect is lost.
// TESTING
//  - Reset, then read every idx via lk_pc -> lk_taken=0 everywhere; counters=0.
//  - BEQ pc=0x1000, r1=r2=5, offs=+0x10, pr_taken=0 -> next cycle res_valid=1,
//    redirect=1, redirect_addr=0x1010, miss_cnt=1, bht[idx(0x1000)]=2'b10.
//  - Same BEQ 3 more times with pr_taken=1 -> no redirect; entry saturates at 11;
//    br_cnt=4, miss_cnt=1.
//  - BLTU r1=1, r2=0xFFFF_FFFF_FFFF_FFFF, pc=0xFFFF_FFFF_FFFF_FFF0, offs=+0x20 -> taken,
//    redirect_addr=0x10 (wrap).
//  - JALR r1=0x2003, imm=0 -> redirect_addr=0x2002, misalign=1. With imm=-3 ->
//    redirect_addr=0x2000, misalign=0.
//  - BNE with stall=1 -> no update or capture. Same BNE with flush=1 and stall=1 ->
//    res_valid=0, counters unchanged.

Source files
------------

// File: rtl/br_unit.sv
// Branch/JALR resolution stage: resolves the EX instruction against the fetch prediction,
// registers a one-cycle-late redirect, trains a table of 2-bit counters and counts branches.
module br_unit #(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [31:0]      ex_ir,
    input  logic [XLEN-1:0]  ex_r1,
    input  logic [XLEN-1:0]  ex_r2,
    input  logic             ex_pr_taken,
    input  logic             stall,
    input  logic             flush,
    input  logic [XLEN-1:0]  lk_pc,
    output logic             lk_taken,
    output logic             res_valid,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_addr,
    output logic             misalign,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IW = $clog2(BHT_DEPTH);
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Two-bit saturating counter step toward taken (up=1) or not-taken (up=0).
    function automatic logic [1:0] sat_step(input logic [1:0] cur, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
        end else begin
            res = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
        end
        return res;
    endfunction

    logic [1:0]      bht_r [BHT_DEPTH];
    logic            res_valid_r, redirect_r, misalign_r;
    logic [XLEN-1:0] redirect_addr_r;
    logic [CNT_W-1:0] br_cnt_r, miss_cnt_r;

    logic [IW-1:0]   ex_idx_s, lk_idx_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic            cap_s, is_br_s, is_jalr_s, cond_s, f3_ok_s, out_en_s;
    logic [XLEN-1:0] imm_b_s, imm_i_s, br_tgt_s, jalr_sum_s, jalr_tgt_s, pc4_s;
    logic            nxt_valid_s, nxt_redir_s, nxt_mis_s;
    logic [XLEN-1:0] nxt_addr_s;
    logic            bht_we_s, br_inc_s, miss_inc_s;
    logic [1:0]      bht_nxt_s;
    logic            unused_bits_s;

    assign opcode_s   = ex_ir[6:0];
    assign funct3_s   = ex_ir[14:12];
    assign cap_s      = ex_valid & ~stall & ~flush;
    assign is_br_s    = (opcode_s == OP_BR);
    assign is_jalr_s  = (opcode_s == OP_JALR);
    assign ex_idx_s   = ex_pc[IW+1:2];
    assign lk_idx_s   = lk_pc[IW+1:2];
    assign imm_b_s    = {{(XLEN-13){ex_ir[31]}}, ex_ir[31], ex_ir[7], ex_ir[30:25], ex_ir[11:8], 1'b0};
    assign imm_i_s    = {{(XLEN-12){ex_ir[31]}}, ex_ir[31:20]};
    assign br_tgt_s   = ex_pc + imm_b_s;
    assign jalr_sum_s = ex_r1 + imm_i_s;
    assign jalr_tgt_s = {jalr_sum_s[XLEN-1:1], 1'b0};
    assign pc4_s      = ex_pc + {{(XLEN-3){1'b0}}, 3'b100};
    // Registered outputs move on a free cycle, or when a flush overrides a stall.
    assign out_en_s   = ~stall | flush;

    // Lookup reads the stored value, so a same-cycle update is not visible yet.
    assign lk_taken = bht_r[lk_idx_s][1];

    assign res_valid     = res_valid_r;
    assign redirect      = redirect_r;
    assign redirect_addr = redirect_addr_r;
    assign misalign      = misalign_r;
    assign br_cnt        = br_cnt_r;
    assign miss_cnt      = miss_cnt_r;

    assign unused_bits_s = ^{ex_ir[19:15], jalr_sum_s[0], lk_pc[1:0], lk_pc[XLEN-1:IW+2]};

    // Branch condition evaluation; funct3 010/011 is flagged illegal and resolves not-taken.
    always_comb begin
        cond_s  = 1'b0;
        f3_ok_s = 1'b1;
        case (funct3_s)
            3'b000:  cond_s = (ex_r1 == ex_r2);
            3'b001:  cond_s = (ex_r1 != ex_r2);
            3'b100:  cond_s = ($signed(ex_r1) <  $signed(ex_r2));
            3'b101:  cond_s = ($signed(ex_r1) >= $signed(ex_r2));
            3'b110:  cond_s = (ex_r1 <  ex_r2);
            3'b111:  cond_s = (ex_r1 >= ex_r2);
            default: begin
                cond_s  = 1'b0;
                f3_ok_s = 1'b0;
            end
        endcase
    end

    // Next output values and training/count enables for the captured instruction.
    always_comb begin
        nxt_valid_s = 1'b0;
        nxt_redir_s = 1'b0;
        nxt_mis_s   = 1'b0;
        nxt_addr_s  = redirect_addr_r;
        bht_we_s    = 1'b0;
        br_inc_s    = 1'b0;
        miss_inc_s  = 1'b0;
        if (cap_s && is_br_s) begin
            nxt_valid_s = 1'b1;
            nxt_redir_s = (cond_s != ex_pr_taken);
            nxt_addr_s  = cond_s ? br_tgt_s : pc4_s;
            nxt_mis_s   = cond_s & br_tgt_s[1];
            bht_we_s    = f3_ok_s;
            br_inc_s    = f3_ok_s;
            miss_inc_s  = f3_ok_s & (cond_s != ex_pr_taken);
        end else if (cap_s && is_jalr_s) begin
            nxt_valid_s = 1'b1;
            nxt_redir_s = 1'b1;
            nxt_addr_s  = jalr_tgt_s;
            nxt_mis_s   = jalr_tgt_s[1];
        end else begin
            nxt_valid_s = 1'b0;
        end
    end

    assign bht_nxt_s = sat_step(bht_r[ex_idx_s], cond_s);

    // Resolution output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r     <= 1'b0;
            redirect_r      <= 1'b0;
            misalign_r      <= 1'b0;
            redirect_addr_r <= {XLEN{1'b0}};
        end else if (out_en_s) begin
            res_valid_r     <= nxt_valid_s;
            redirect_r      <= nxt_redir_s;
            misalign_r      <= nxt_mis_s;
            redirect_addr_r <= nxt_addr_s;
        end
    end

    // Branch history table training.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (bht_we_s) begin
            bht_r[ex_idx_s] <= bht_nxt_s;
        end
    end

    // Performance counters, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_r   <= {CNT_W{1'b0}};
            miss_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (br_inc_s) begin
                br_cnt_r <= br_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (miss_inc_s) begin
                miss_cnt_r <= miss_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_br_unit.sv
// Self-checking bench for br_unit: a behavioural model pushes expected outputs per cycle,
// popped and compared after each clock edge, plus fixed-value checks on known scenarios.
module tb_br_unit;
    localparam int XLEN = 64;
    localparam int DEPTH = 64;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_r1, ex_r2, lk_pc;
    logic [31:0]     ex_ir;
    logic            ex_pr_taken, stall, flush;
    logic            lk_taken, res_valid, redirect, misalign;
    logic [XLEN-1:0] redirect_addr;
    logic [CW-1:0]   br_cnt, miss_cnt;

    always #5 clk = ~clk;

    br_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ir(ex_ir),
        .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_pr_taken(ex_pr_taken), .stall(stall), .flush(flush),
        .lk_pc(lk_pc), .lk_taken(lk_taken), .res_valid(res_valid), .redirect(redirect),
        .redirect_addr(redirect_addr), .misalign(misalign), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct packed {
        logic        rv;
        logic        rd;
        logic [63:0] addr;
        logic        mis;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       m_out;
    logic [1:0] bht_m [DEPTH];
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] off);
        return {off[12], off[10:5], 5'd2, 5'd1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic model_reset();
        m_out = '0;
        for (int i = 0; i < DEPTH; i++) bht_m[i] = 2'b01;
        exp_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [63:0] pc, input logic [31:0] ir,
                              input logic [63:0] r1, input logic [63:0] r2, input logic pr,
                              input logic st, input logic fl);
        logic t, ok;
        logic [63:0] bt, jt;
        int ix;
        if (st && !fl) begin
            // outputs and state hold
        end else if (fl || !v) begin
            m_out.rv = 1'b0; m_out.rd = 1'b0; m_out.mis = 1'b0;
        end else if (ir[6:0] == 7'b1100011) begin
            ok = 1'b1;
            case (ir[14:12])
                3'b000: t = (r1 == r2);
                3'b001: t = (r1 != r2);
                3'b100: t = ($signed(r1) < $signed(r2));
                3'b101: t = !($signed(r1) < $signed(r2));
                3'b110: t = (r1 < r2);
                3'b111: t = !(r1 < r2);
                default: begin t = 1'b0; ok = 1'b0; end
            endcase
            bt = pc + {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            m_out.rv   = 1'b1;
            m_out.rd   = (t != pr);
            m_out.addr = t ? bt : pc + 64'd4;
            m_out.mis  = t & bt[1];
            if (ok) begin
                m_out.bc = m_out.bc + 32'd1;
                if (t != pr) m_out.mc = m_out.mc + 32'd1;
                ix = int'(pc[7:2]);
                if (t && bht_m[ix] != 2'b11) bht_m[ix] = bht_m[ix] + 2'b01;
                if (!t && bht_m[ix] != 2'b00) bht_m[ix] = bht_m[ix] - 2'b01;
            end
        end else if (ir[6:0] == 7'b1100111) begin
            jt = (r1 + {{52{ir[31]}}, ir[31:20]}) & ~64'd1;
            m_out.rv = 1'b1; m_out.rd = 1'b1; m_out.addr = jt; m_out.mis = jt[1];
        end else begin
            m_out.rv = 1'b0; m_out.rd = 1'b0; m_out.mis = 1'b0;
        end
        exp_q.push_back(m_out);
    endtask

    task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] ir,
                         input logic [63:0] r1, input logic [63:0] r2, input logic pr,
                         input logic st, input logic fl);
        exp_t e;
        ex_valid = v; ex_pc = pc; ex_ir = ir; ex_r1 = r1; ex_r2 = r2;
        ex_pr_taken = pr; stall = st; flush = fl;
        model_step(v, pc, ir, r1, r2, pr, st, fl);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("res_valid", {63'd0, res_valid}, {63'd0, e.rv});
        check_eq("redirect", {63'd0, redirect}, {63'd0, e.rd});
        check_eq("redirect_addr", redirect_addr, e.addr);
        check_eq("misalign", {63'd0, misalign}, {63'd0, e.mis});
        check_eq("br_cnt", {32'd0, br_cnt}, {32'd0, e.bc});
        check_eq("miss_cnt", {32'd0, miss_cnt}, {32'd0, e.mc});
        ex_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic check_lk(input logic [63:0] pc);
        lk_pc = pc;
        #1;
        check_eq("lk_taken", {63'd0, lk_taken}, {63'd0, bht_m[int'(pc[7:2])][1]});
    endtask

    initial begin
        logic [63:0] rpc, rr1, rr2;
        logic [31:0] rir;
        logic [12:0] roff;
        rst_n = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_ir = '0; ex_r1 = '0; ex_r2 = '0;
        ex_pr_taken = 1'b0; stall = 1'b0; flush = 1'b0; lk_pc = '0;
        model_reset();
        @(posedge clk); #1;
        check_eq("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check_eq("rst_redirect", {63'd0, redirect}, 64'd0);
        check_eq("rst_addr", redirect_addr, 64'd0);
        check_eq("rst_misalign", {63'd0, misalign}, 64'd0);
        check_eq("rst_br_cnt", {32'd0, br_cnt}, 64'd0);
        check_eq("rst_miss_cnt", {32'd0, miss_cnt}, 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            lk_pc = 64'(i) << 2;
            #1;
            check_eq("rst_lk", {63'd0, lk_taken}, 64'd0);
        end
        rst_n = 1'b1;

        // BEQ taken, predicted not-taken
        cycle(1'b1, 64'h1000, enc_b(3'b000, 13'h10), 64'd5, 64'd5, 1'b0, 1'b0, 1'b0);
        check_eq("beq1_redirect", {63'd0, redirect}, 64'd1);
        check_eq("beq1_addr", redirect_addr, 64'h1010);
        check_eq("beq1_miss", {32'd0, miss_cnt}, 64'd1);
        lk_pc = 64'h1000; #1;
        check_eq("beq1_lk", {63'd0, lk_taken}, 64'd1);
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 64'h1000, enc_b(3'b000, 13'h10), 64'd5, 64'd5, 1'b1, 1'b0, 1'b0);
        check_eq("beq4_redirect", {63'd0, redirect}, 64'd0);
        check_eq("beq4_br", {32'd0, br_cnt}, 64'd4);
        check_eq("beq4_miss", {32'd0, miss_cnt}, 64'd1);
        // one not-taken from a saturated 11 still predicts taken
        cycle(1'b1, 64'h1000, enc_b(3'b000, 13'h10), 64'd5, 64'd6, 1'b1, 1'b0, 1'b0);
        check_eq("beqnt_addr", redirect_addr, 64'h1004);
        lk_pc = 64'h1000; #1;
        check_eq("sat_lk", {63'd0, lk_taken}, 64'd1);
        check_lk(64'h1000);

        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, enc_b(3'b110, 13'h20), 64'd1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check_eq("bltu_wrap_addr", redirect_addr, 64'h10);
        check_eq("bltu_redirect", {63'd0, redirect}, 64'd1);

        cycle(1'b1, 64'h3000, enc_jalr(12'h000), 64'h2003, 64'd0, 1'b0, 1'b0, 1'b0);
        check_eq("jalr0_addr", redirect_addr, 64'h2002);
        check_eq("jalr0_mis", {63'd0, misalign}, 64'd1);
        cycle(1'b1, 64'h3000, enc_jalr(12'hFFD), 64'h2003, 64'd0, 1'b0, 1'b0, 1'b0);
        check_eq("jalrm3_addr", redirect_addr, 64'h2000);
        check_eq("jalrm3_mis", {63'd0, misalign}, 64'd0);

        // BNE under stall: outputs hold, nothing counted
        cycle(1'b1, 64'h4000, enc_b(3'b001, 13'h40), 64'd1, 64'd2, 1'b0, 1'b1, 1'b0);
        check_eq("stall_hold_valid", {63'd0, res_valid}, 64'd1);
        check_eq("stall_hold_addr", redirect_addr, 64'h2000);
        check_eq("stall_br", {32'd0, br_cnt}, 64'd6);
        check_eq("stall_miss", {32'd0, miss_cnt}, 64'd3);
        check_lk(64'h4000);
        cycle(1'b1, 64'h4000, enc_b(3'b001, 13'h40), 64'd1, 64'd2, 1'b0, 1'b1, 1'b1);
        check_eq("flush_valid", {63'd0, res_valid}, 64'd0);
        check_eq("flush_addr", redirect_addr, 64'h2000);
        check_eq("flush_br", {32'd0, br_cnt}, 64'd6);
        check_lk(64'h4000);

        // illegal funct3: not counted, table untouched
        cycle(1'b1, 64'h1000, enc_b(3'b010, 13'h10), 64'd5, 64'd5, 1'b0, 1'b0, 1'b0);
        check_eq("ill_br", {32'd0, br_cnt}, 64'd6);
        check_eq("ill_redirect", {63'd0, redirect}, 64'd0);
        check_lk(64'h1000);

        for (int n = 0; n < 300; n++) begin
            rpc  = {$urandom(), $urandom()} & ~64'd3;
            roff = 13'($urandom());
            rr1  = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 3));
            rr2  = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1:    rir = enc_b(3'($urandom_range(0, 7)), roff);
                2:       rir = enc_jalr(12'($urandom()));
                default: rir = {$urandom()} & ~32'h7F | 32'h33;
            endcase
            cycle(($urandom_range(0, 5) != 0), rpc, rir, rr1, rr2, 1'($urandom()),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
            check_lk(64'($urandom_range(0, 255)));
        end

        // reset in the middle of a pending redirect
        cycle(1'b1, 64'h1000, enc_b(3'b000, 13'h10), 64'd7, 64'd7, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("midrst_redirect", {63'd0, redirect}, 64'd0);
        check_eq("midrst_valid", {63'd0, res_valid}, 64'd0);
        check_eq("midrst_br", {32'd0, br_cnt}, 64'd0);
        check_lk(64'h1000);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 64'd0, 32'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
